btn_event_arbiter: RTL and testbench

- Collects button/switch events from N_BTN asynchronous inputs and presents them to the PicoBlaze one at a time over a single interrupt line.
- Each channel is synchronized, debounced and reduced to a one-cycle rising-edge pulse, which sets a pending flag.
- An arbiter FSM selects one pending channel, raises irq with its index on evt_id, and clears that flag on the processor's interrupt acknowledge.
- Sits between the board push-buttons/switches and the PicoBlaze interrupt and input ports.

---
 rtl/btn_event_arbiter.sv | 211 +++++++++++++++++++++
 tb/tb_btn_event_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_event_arbiter.sv
// Button/switch event collector: per-channel sync, debounce and rise detection, pending
// flags and a one-at-a-time interrupt arbiter. Define BTN_ARB_ROUND_ROBIN_EN for round-robin grants.
`timescale 1ns/1ps

module btn_event_arbiter #(
    parameter  int ID_W       = 2,
    parameter  int DEB_CYCLES = 50000,
    parameter  int DEB_W      = 16,
    localparam int N_BTN      = 2**ID_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_in,
    output logic             irq,
    input  logic             irq_ack,
    output logic [ID_W-1:0]  evt_id,
    output logic [N_BTN-1:0] pending,
    output logic             ovf,
    input  logic             clr
);

    localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {
        EDGE_IDLE,
        EDGE_PULSE,
        EDGE_HOLD
    } edge_state_t;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_REQ,
        ARB_GAP
    } arb_state_t;

    logic [N_BTN-1:0] sync1_reg;
    logic [N_BTN-1:0] sync_reg;
    logic [N_BTN-1:0] rise;
    logic [N_BTN-1:0] ack_hit;
    logic [N_BTN-1:0] ovf_set;
    logic [N_BTN-1:0] pending_reg;
    logic [N_BTN-1:0] pending_next;
    logic             ovf_reg;
    logic             irq_reg;
    logic [ID_W-1:0]  evt_id_reg;
    logic [ID_W-1:0]  evt_id_next;
    logic [ID_W-1:0]  sel_id;
    logic             ack_fire;
    arb_state_t       arb_state_reg;
    arb_state_t       arb_state_next;

    // Two-stage synchronizer; btn_in is asynchronous to clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_reg <= '0;
            sync_reg  <= '0;
        end else begin
            sync1_reg <= btn_in;
            sync_reg  <= sync1_reg;
        end
    end

    // An acknowledge only counts while a request is actually outstanding.
    assign ack_fire = (arb_state_reg == ARB_REQ) && irq_ack;

    genvar gi;
    generate
        for (gi = 0; gi < N_BTN; gi++) begin : g_chan
            logic [DEB_W-1:0] cnt_reg;
            logic             stable_reg;
            edge_state_t      edge_state_reg;
            edge_state_t      edge_state_next;

            // Any cycle of agreement restarts the count, so only an unbroken
            // run of DEB_CYCLES differing cycles moves the stable level.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_reg    <= '0;
                    stable_reg <= 1'b0;
                end else if (sync_reg[gi] == stable_reg) begin
                    cnt_reg <= '0;
                end else if (cnt_reg == DEB_MAX) begin
                    stable_reg <= sync_reg[gi];
                    cnt_reg    <= '0;
                end else begin
                    cnt_reg <= cnt_reg + DEB_W'(1);
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    edge_state_reg <= EDGE_IDLE;
                end else begin
                    edge_state_reg <= edge_state_next;
                end
            end

            always_comb begin
                edge_state_next = edge_state_reg;
                case (edge_state_reg)
                    EDGE_IDLE:  if (stable_reg)  edge_state_next = EDGE_PULSE;
                    EDGE_PULSE: edge_state_next = EDGE_HOLD;
                    EDGE_HOLD:  if (!stable_reg) edge_state_next = EDGE_IDLE;
                    default:    edge_state_next = EDGE_IDLE;
                endcase
            end

            assign rise[gi]    = (edge_state_reg == EDGE_PULSE);
            assign ack_hit[gi] = ack_fire && (evt_id_reg == ID_W'(gi));

            // A fresh rise beats both clears so an event landing on its own ack is not lost.
            assign pending_next[gi] = rise[gi]                ? 1'b1 :
                                      (ack_hit[gi] || clr)    ? 1'b0 :
                                                                pending_reg[gi];

            assign ovf_set[gi] = rise[gi] && pending_reg[gi] && !ack_hit[gi];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_reg <= '0;
            ovf_reg     <= 1'b0;
        end else begin
            pending_reg <= pending_next;
            ovf_reg     <= (|ovf_set) || (ovf_reg && !clr);
        end
    end

`ifdef BTN_ARB_ROUND_ROBIN_EN
    logic [ID_W-1:0] last_grant_reg;
    logic [ID_W-1:0] cand;
    logic            sel_found;

    // Starting at N_BTN-1 makes the first search begin at index 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_reg <= ID_W'(N_BTN - 1);
        end else if (ack_fire) begin
            last_grant_reg <= evt_id_reg;
        end
    end

    // Index arithmetic wraps naturally because N_BTN is a power of two.
    always_comb begin
        sel_id    = '0;
        sel_found = 1'b0;
        cand      = '0;
        for (int k = 0; k < N_BTN; k++) begin
            cand = last_grant_reg + ID_W'(k + 1);
            if (!sel_found && pending_reg[cand]) begin
                sel_id    = cand;
                sel_found = 1'b1;
            end
        end
    end
`else
    // Scan downward so the lowest pending index is the last to be written.
    always_comb begin
        sel_id = '0;
        for (int k = N_BTN - 1; k >= 0; k--) begin
            if (pending_reg[k]) begin
                sel_id = ID_W'(k);
            end
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            arb_state_reg <= ARB_IDLE;
            evt_id_reg    <= '0;
            irq_reg       <= 1'b0;
        end else begin
            arb_state_reg <= arb_state_next;
            evt_id_reg    <= evt_id_next;
            irq_reg       <= (arb_state_next == ARB_REQ);
        end
    end

    // A clr during ARB_REQ does not abort the request; the processor still acks it.
    always_comb begin
        arb_state_next = arb_state_reg;
        evt_id_next    = evt_id_reg;
        case (arb_state_reg)
            ARB_IDLE: begin
                if (|pending_reg) begin
                    evt_id_next    = sel_id;
                    arb_state_next = ARB_REQ;
                end
            end
            ARB_REQ: begin
                if (irq_ack) begin
                    arb_state_next = ARB_GAP;
                end
            end
            ARB_GAP: begin
                arb_state_next = ARB_IDLE;
            end
            default: begin
                arb_state_next = ARB_IDLE;
            end
        endcase
    end

    assign irq     = irq_reg;
    assign evt_id  = evt_id_reg;
    assign pending = pending_reg;
    assign ovf     = ovf_reg;

endmodule

// File: tb/tb_btn_event_arbiter.sv
// Directed bench for btn_event_arbiter with DEB_CYCLES=4; expectations follow the
// fixed-priority build unless BTN_ARB_ROUND_ROBIN_EN is defined.
`timescale 1ns/1ps

module tb_btn_event_arbiter;

    localparam int ID_W = 2;
    localparam int N    = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  btn_in = '0;
    logic          irq;
    logic          irq_ack = 1'b0;
    logic [ID_W-1:0] evt_id;
    logic [N-1:0]  pending;
    logic          ovf;
    logic          clr = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    btn_event_arbiter #(
        .ID_W(ID_W),
        .DEB_CYCLES(4),
        .DEB_W(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_in(btn_in),
        .irq(irq),
        .irq_ack(irq_ack),
        .evt_id(evt_id),
        .pending(pending),
        .ovf(ovf),
        .clr(clr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [N-1:0] b);
        btn_in  = b;
        irq_ack = 1'b0;
        clr     = 1'b0;
        rst     = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic pulse_ack();
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
    endtask

    task automatic wait_irq(input int max_cycles, output bit got);
        got = 1'b0;
        for (int i = 0; i < max_cycles && !got; i++) begin
            tick();
            if (irq === 1'b1) got = 1'b1;
        end
    endtask

    task automatic test_reset();
        logic [N-1:0] exp_p;
        logic         exp_i;
        btn_in = 4'hF;
        rst = 1'b1;
        tick();
        tick();
        vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL reset_irq: got %0h expected 0", irq); end
        vectors++; if (pending !== 4'h0) begin miscompares++; $display("FAIL reset_pending: got %0h expected 0", pending); end
        vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL reset_ovf: got %0h expected 0", ovf); end
        vectors++; if (evt_id !== 2'd0) begin miscompares++; $display("FAIL reset_evt_id: got %0h expected 0", evt_id); end
        rst = 1'b0;
        for (int e = 1; e <= 9; e++) begin
            tick();
            exp_p = (e >= 8) ? 4'hF : 4'h0;
            exp_i = (e >= 9);
            vectors++;
            if (pending !== exp_p) begin miscompares++; $display("FAIL reset_rise_pending edge %0d: got %0h expected %0h", e, pending, exp_p); end
            vectors++;
            if (irq !== exp_i) begin miscompares++; $display("FAIL reset_rise_irq edge %0d: got %0h expected %0h", e, irq, exp_i); end
        end
        vectors++; if (evt_id !== 2'd0) begin miscompares++; $display("FAIL reset_rise_evt_id: got %0h expected 0", evt_id); end
        $display("test_reset done");
    endtask

    task automatic test_bounce();
        bit seen;
        do_reset(4'h0);
        seen = 1'b0;
        for (int ph = 0; ph < 10; ph++) begin
            btn_in[2] = ((ph % 2) == 0);
            tick(); if (irq === 1'b1 || pending !== 4'h0) seen = 1'b1;
            tick(); if (irq === 1'b1 || pending !== 4'h0) seen = 1'b1;
        end
        vectors++; if (seen) begin miscompares++; $display("FAIL bounce_no_event: got 1 expected 0"); end
        btn_in[2] = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            if (e == 7) begin
                vectors++; if (pending !== 4'h0) begin miscompares++; $display("FAIL bounce_pending_e7: got %0h expected 0", pending); end
            end
        end
        vectors++; if (pending !== 4'h4) begin miscompares++; $display("FAIL bounce_pending_e8: got %0h expected 4", pending); end
        tick();
        vectors++; if (irq !== 1'b1) begin miscompares++; $display("FAIL bounce_irq_e9: got %0h expected 1", irq); end
        vectors++; if (evt_id !== 2'd2) begin miscompares++; $display("FAIL bounce_evt_id: got %0h expected 2", evt_id); end
        pulse_ack();
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (irq === 1'b1 || pending !== 4'h0) seen = 1'b1;
        end
        vectors++; if (seen) begin miscompares++; $display("FAIL bounce_single_event: got extra event expected none"); end
        $display("test_bounce done");
    endtask

    task automatic test_priority();
        bit got;
        logic [ID_W-1:0] exp_first;
        logic [ID_W-1:0] exp_second;
`ifdef BTN_ARB_ROUND_ROBIN_EN
        exp_first  = 2'd3;
        exp_second = 2'd1;
`else
        exp_first  = 2'd1;
        exp_second = 2'd3;
`endif
        do_reset(4'h0);
        btn_in = 4'b0010;
        wait_irq(20, got);
        vectors++; if (!got) begin miscompares++; $display("FAIL prio_first_irq: got timeout expected irq"); end
        vectors++; if (evt_id !== 2'd1) begin miscompares++; $display("FAIL prio_warmup_evt_id: got %0h expected 1", evt_id); end
        pulse_ack();
        btn_in = 4'b0000;
        repeat (12) tick();
        btn_in = 4'b1010;
        wait_irq(20, got);
        vectors++; if (!got) begin miscompares++; $display("FAIL prio_pair_irq: got timeout expected irq"); end
        vectors++; if (pending !== 4'b1010) begin miscompares++; $display("FAIL prio_pending: got %0h expected a", pending); end
        vectors++; if (evt_id !== exp_first) begin miscompares++; $display("FAIL prio_first_evt_id: got %0h expected %0h", evt_id, exp_first); end
        pulse_ack();
        vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL prio_irq_fall: got %0h expected 0", irq); end
        vectors++; if (pending !== (4'b1010 & ~(4'b0001 << exp_first))) begin miscompares++; $display("FAIL prio_pending_after_ack: got %0h expected %0h", pending, 4'b1010 & ~(4'b0001 << exp_first)); end
        tick();
        vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL prio_gap2: got %0h expected 0", irq); end
        tick();
        vectors++; if (irq !== 1'b1) begin miscompares++; $display("FAIL prio_second_irq: got %0h expected 1", irq); end
        vectors++; if (evt_id !== exp_second) begin miscompares++; $display("FAIL prio_second_evt_id: got %0h expected %0h", evt_id, exp_second); end
        pulse_ack();
        vectors++; if (pending !== 4'h0) begin miscompares++; $display("FAIL prio_pending_clear: got %0h expected 0", pending); end
        $display("test_priority done");
    endtask

    task automatic test_overflow();
        bit got;
        do_reset(4'h0);
        btn_in = 4'b0001;
        wait_irq(20, got);
        vectors++; if (!got) begin miscompares++; $display("FAIL ovf_first_irq: got timeout expected irq"); end
        vectors++; if (evt_id !== 2'd0) begin miscompares++; $display("FAIL ovf_evt_id: got %0h expected 0", evt_id); end
        vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL ovf_before: got %0h expected 0", ovf); end
        btn_in = 4'b0000;
        repeat (12) tick();
        btn_in = 4'b0001;
        repeat (12) tick();
        vectors++; if (ovf !== 1'b1) begin miscompares++; $display("FAIL ovf_set: got %0h expected 1", ovf); end
        vectors++; if (pending !== 4'b0001) begin miscompares++; $display("FAIL ovf_pending: got %0h expected 1", pending); end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        vectors++; if (pending !== 4'h0) begin miscompares++; $display("FAIL clr_pending: got %0h expected 0", pending); end
        vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL clr_ovf: got %0h expected 0", ovf); end
        vectors++; if (irq !== 1'b1) begin miscompares++; $display("FAIL clr_irq_held: got %0h expected 1", irq); end
        pulse_ack();
        vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL clr_ack_irq: got %0h expected 0", irq); end
        tick();
        tick();
        vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL clr_no_reraise: got %0h expected 0", irq); end
        $display("test_overflow done");
    endtask

    task automatic test_ack_collision();
        bit got;
        do_reset(4'h0);
        btn_in = 4'b0010;
        wait_irq(20, got);
        vectors++; if (!got) begin miscompares++; $display("FAIL coll_first_irq: got timeout expected irq"); end
        vectors++; if (evt_id !== 2'd1) begin miscompares++; $display("FAIL coll_evt_id: got %0h expected 1", evt_id); end
        btn_in = 4'b0000;
        repeat (12) tick();
        btn_in = 4'b0010;
        repeat (7) tick();
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        vectors++; if (pending !== 4'b0010) begin miscompares++; $display("FAIL coll_pending_kept: got %0h expected 2", pending); end
        vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL coll_irq_gap: got %0h expected 0", irq); end
        vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL coll_no_ovf: got %0h expected 0", ovf); end
        tick();
        vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL coll_irq_idle: got %0h expected 0", irq); end
        tick();
        vectors++; if (irq !== 1'b1) begin miscompares++; $display("FAIL coll_reraise: got %0h expected 1", irq); end
        vectors++; if (evt_id !== 2'd1) begin miscompares++; $display("FAIL coll_reraise_evt_id: got %0h expected 1", evt_id); end
        $display("test_ack_collision done");
    endtask

    task automatic test_reset_mid();
        bit got;
        bit seen;
        do_reset(4'h0);
        btn_in = 4'b0100;
        wait_irq(20, got);
        vectors++; if (!got) begin miscompares++; $display("FAIL rstmid_irq: got timeout expected irq"); end
        vectors++; if (evt_id !== 2'd2) begin miscompares++; $display("FAIL rstmid_evt_id_before: got %0h expected 2", evt_id); end
        #1;
        rst = 1'b1;
        #1;
        vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL rstmid_irq_async: got %0h expected 0", irq); end
        vectors++; if (pending !== 4'h0) begin miscompares++; $display("FAIL rstmid_pending_async: got %0h expected 0", pending); end
        vectors++; if (evt_id !== 2'd0) begin miscompares++; $display("FAIL rstmid_evt_id_async: got %0h expected 0", evt_id); end
        btn_in = 4'b0000;
        tick();
        tick();
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (irq === 1'b1 || pending !== 4'h0) seen = 1'b1;
        end
        vectors++; if (seen) begin miscompares++; $display("FAIL rstmid_quiet: got event expected none"); end
        $display("test_reset_mid done");
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_priority();
        test_overflow();
        test_ack_collision();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
